// File: rtl/dibit_frame_source_if.sv
// Handshake bundle between the frame source and its user: buffer writes,
// frame control, status and the dibit stream.
interface dibit_frame_source_if #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 16
);
    logic                           wr_en;
    logic [WORD_W-1:0]              wr_data;
    logic                           clear;
    logic                           start;
    logic                           repeat_mode;
    logic                           wr_full;
    logic [$clog2(DEPTH+1)-1:0]     count;
    logic                           busy;
    logic                           done;
    logic                           axiov;
    logic [1:0]                     axiod;

    modport master (
        output wr_en, wr_data, clear, start, repeat_mode,
        input  wr_full, count, busy, done, axiov, axiod
    );

    modport slave (
        input  wr_en, wr_data, clear, start, repeat_mode,
        output wr_full, count, busy, done, axiov, axiod
    );
endinterface

// File: rtl/dibit_frame_source.sv
// Buffered frame payload source: serialises stored words MSB-first as dibits,
// zero-pads short frames to a minimum length and enforces an inter-frame gap.
//
// state | meaning
// IDLE  | buffer writable, waiting for start
// SEND  | outputs carry a payload dibit
// PAD   | outputs carry a zero pad dibit (axiov=1)
// GAP   | inter-frame gap, axiov=0
module dibit_frame_source #(
    parameter int WORD_W     = 32,
    parameter int DEPTH      = 16,
    parameter int MIN_DIBITS = 184,
    parameter int IFG_CYCLES = 48
) (
    input  logic                  clk,
    input  logic                  rstn,
    dibit_frame_source_if.slave   bus
);
    localparam int DPW     = WORD_W / 2;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MAX_DIB = (DEPTH * DPW > MIN_DIBITS) ? DEPTH * DPW : MIN_DIBITS;
    localparam int TOT_W   = $clog2(MAX_DIB + 1);
    localparam int DL_W    = (DPW > 1) ? $clog2(DPW) : 1;
    localparam int GAP_W   = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_PAD, S_GAP} state_t;

    state_t             r_state;
    logic [WORD_W-1:0]  r_mem [DEPTH];
    logic [CNT_W-1:0]   r_count;
    logic               r_wr_full;
    logic [TOT_W-1:0]   r_len;
    logic [TOT_W-1:0]   r_total;
    logic [AW-1:0]      r_word_ptr;
    logic [WORD_W-1:0]  r_shift;
    logic [DL_W-1:0]    r_dib_left;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_axiov;
    logic [1:0]         r_axiod;

    logic               w_idle;
    logic               w_start_ok;
    logic               w_wr_accept;
    logic [AW-1:0]      w_next_addr;
    logic [WORD_W-1:0]  w_first_word;
    logic [WORD_W-1:0]  w_next_word;
    logic [TOT_W-1:0]   w_frame_len;

    // clear outranks start, start outranks a write
    assign w_idle       = (r_state == S_IDLE);
    assign w_start_ok   = w_idle && !bus.clear && bus.start && (r_count != '0);
    assign w_wr_accept  = w_idle && !bus.clear && !bus.start && bus.wr_en && !r_wr_full;
    assign w_next_addr  = r_word_ptr + AW'(1);
    assign w_first_word = r_mem[0];
    assign w_next_word  = r_mem[w_next_addr];
    assign w_frame_len  = TOT_W'(r_count) * TOT_W'(DPW);

    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_count[AW-1:0]] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_wr_full  <= 1'b0;
            r_len      <= '0;
            r_total    <= '0;
            r_word_ptr <= '0;
            r_shift    <= '0;
            r_dib_left <= '0;
            r_gap_cnt  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_axiov    <= 1'b0;
            r_axiod    <= 2'b00;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.clear) begin
                        r_count   <= '0;
                        r_wr_full <= 1'b0;
                    end else if (w_start_ok) begin
                        r_len      <= w_frame_len;
                        r_state    <= S_SEND;
                        r_busy     <= 1'b1;
                        r_axiov    <= 1'b1;
                        r_axiod    <= w_first_word[WORD_W-1 -: 2];
                        r_shift    <= w_first_word << 2;
                        r_dib_left <= DL_W'(DPW - 1);
                        r_word_ptr <= '0;
                        r_total    <= TOT_W'(1);
                    end else if (w_wr_accept) begin
                        r_count   <= r_count + CNT_W'(1);
                        r_wr_full <= ((r_count + CNT_W'(1)) == CNT_W'(DEPTH));
                    end
                end
                S_SEND: begin
                    if (r_total < r_len) begin
                        if (r_dib_left != '0) begin
                            r_axiod    <= r_shift[WORD_W-1 -: 2];
                            r_shift    <= r_shift << 2;
                            r_dib_left <= r_dib_left - DL_W'(1);
                        end else begin
                            r_axiod    <= w_next_word[WORD_W-1 -: 2];
                            r_shift    <= w_next_word << 2;
                            r_dib_left <= DL_W'(DPW - 1);
                            r_word_ptr <= w_next_addr;
                        end
                        r_total <= r_total + TOT_W'(1);
                    end else if (r_total < TOT_W'(MIN_DIBITS)) begin
                        r_state <= S_PAD;
                        r_axiod <= 2'b00;
                        r_total <= r_total + TOT_W'(1);
                    end else begin
                        r_state   <= S_GAP;
                        r_axiov   <= 1'b0;
                        r_axiod   <= 2'b00;
                        r_gap_cnt <= GAP_W'(IFG_CYCLES - 1);
                    end
                end
                S_PAD: begin
                    if (r_total < TOT_W'(MIN_DIBITS)) begin
                        r_axiod <= 2'b00;
                        r_total <= r_total + TOT_W'(1);
                    end else begin
                        r_state   <= S_GAP;
                        r_axiov   <= 1'b0;
                        r_axiod   <= 2'b00;
                        r_gap_cnt <= GAP_W'(IFG_CYCLES - 1);
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt != '0) begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end else if (bus.repeat_mode) begin
                        // back-to-back retransmit with the latched length
                        r_state    <= S_SEND;
                        r_axiov    <= 1'b1;
                        r_axiod    <= w_first_word[WORD_W-1 -: 2];
                        r_shift    <= w_first_word << 2;
                        r_dib_left <= DL_W'(DPW - 1);
                        r_word_ptr <= '0;
                        r_total    <= TOT_W'(1);
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.wr_full = r_wr_full;
    assign bus.count   = r_count;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.axiov   = r_axiov;
    assign bus.axiod   = r_axiod;
endmodule

// File: tb/tb_dibit_frame_source.sv
// Bench for dibit_frame_source: random payloads compared cycle by cycle
// against a word-list model of frame, pad, gap and done.
module tb_dibit_frame_source;
    localparam int WORD_W = 32;
    localparam int DEPTH  = 4;
    localparam int MIN_D  = 24;
    localparam int IFG    = 6;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    dibit_frame_source_if #(.WORD_W(WORD_W), .DEPTH(DEPTH)) bus ();

    dibit_frame_source #(
        .WORD_W(WORD_W), .DEPTH(DEPTH), .MIN_DIBITS(MIN_D), .IFG_CYCLES(IFG)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] model_buf [$];
    logic [4:0]  exp_q [$];   // {busy, done, axiov, axiod}
    logic [4:0]  obs_q [$];

    function automatic void add_frame();
        int total = 0;
        logic [1:0] dib;
        foreach (model_buf[w]) begin
            for (int k = 0; k < 16; k++) begin
                dib = 2'((model_buf[w] >> (30 - 2 * k)) & 32'd3);
                exp_q.push_back({3'b101, dib});
                total++;
            end
        end
        while (total < MIN_D) begin
            exp_q.push_back(5'b10100);
            total++;
        end
        for (int g = 0; g < IFG; g++) exp_q.push_back(5'b10000);
    endfunction

    function automatic void add_done();
        exp_q.push_back(5'b01000);
    endfunction

    function automatic void add_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(5'b00000);
    endfunction

    task automatic capture(input int n, input int drop_at, input int poke_at);
        obs_q.delete();
        for (int i = 0; i < n; i++) begin
            obs_q.push_back({bus.busy, bus.done, bus.axiov, bus.axiod});
            bus.start = 1'b0;
            bus.wr_en = 1'b0;
            if (i == drop_at) bus.repeat_mode = 1'b0;
            if (i == poke_at) begin
                bus.start   = 1'b1;
                bus.wr_en   = 1'b1;
                bus.wr_data = $urandom;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
    endtask

    task automatic write_word(input logic [31:0] w);
        bus.wr_en   = 1'b1;
        bus.wr_data = w;
        @(negedge clk);
        bus.wr_en = 1'b0;
        if (model_buf.size() < DEPTH) model_buf.push_back(w);
    endtask

    task automatic clear_buf();
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        model_buf.delete();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (bus.busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0)    begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_checks++; if (bus.axiov !== 1'b0)   begin n_fail++; $display("FAIL reset_axiov got %b want 0", bus.axiov); end
        n_checks++; if (bus.axiod !== 2'b00)  begin n_fail++; $display("FAIL reset_axiod got %b want 00", bus.axiod); end
        n_checks++; if (bus.wr_full !== 1'b0) begin n_fail++; $display("FAIL reset_wr_full got %b want 0", bus.wr_full); end
        n_checks++; if (bus.count !== 3'd0)   begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.count); end
    endtask

    task automatic test_single_word();
        logic [1:0] golden [16] = '{3,3,3,2,3,2,3,1,2,3,3,2,3,2,3,3};
        clear_buf();
        write_word(32'hFEED_BEEF);
        n_checks++; if (bus.count !== 3'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", bus.count); end
        pulse_start();
        exp_q.delete(); add_frame(); add_done();
        capture(exp_q.size(), -1, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL single_frame cyc %0d got %b want %b", i, obs_q[i], exp_q[i]); end
        end
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (obs_q[k][1:0] !== golden[k]) begin n_fail++; $display("FAIL single_golden dibit %0d got %0d want %0d", k, obs_q[k][1:0], golden[k]); end
        end
        n_checks++; if (bus.count !== 3'd1) begin n_fail++; $display("FAIL single_count_after got %0d want 1", bus.count); end
    endtask

    task automatic test_full();
        clear_buf();
        for (int i = 0; i < DEPTH; i++) write_word($urandom);
        n_checks++; if (bus.wr_full !== 1'b1) begin n_fail++; $display("FAIL full_flag got %b want 1", bus.wr_full); end
        write_word($urandom);
        n_checks++; if (bus.count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d want 4", bus.count); end
        pulse_start();
        exp_q.delete(); add_frame(); add_done();
        capture(exp_q.size(), -1, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_frame cyc %0d got %b want %b", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (bus.count !== 3'd4) begin n_fail++; $display("FAIL full_count_after got %0d want 4", bus.count); end
    endtask

    task automatic test_repeat();
        clear_buf();
        write_word($urandom);
        bus.repeat_mode = 1'b1;
        pulse_start();
        exp_q.delete();
        for (int f = 0; f < 4; f++) add_frame();
        add_done();
        capture(exp_q.size(), 3 * (MIN_D + IFG) + 10, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL repeat_frame cyc %0d got %b want %b", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_ignored();
        clear_buf();
        pulse_start();
        exp_q.delete(); add_idle(8);
        capture(exp_q.size(), -1, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL empty_start cyc %0d got %b want %b", i, obs_q[i], exp_q[i]); end
        end
        write_word($urandom);
        pulse_start();
        exp_q.delete(); add_frame(); add_done();
        capture(exp_q.size(), -1, 5);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL busy_poke cyc %0d got %b want %b", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (bus.count !== 3'd1) begin n_fail++; $display("FAIL busy_write_count got %0d want 1", bus.count); end
        bus.clear = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        bus.start = 1'b0;
        model_buf.delete();
        exp_q.delete(); add_idle(8);
        capture(exp_q.size(), -1, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL clear_start cyc %0d got %b want %b", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL clear_start_count got %0d want 0", bus.count); end
    endtask

    task automatic test_reset_mid();
        write_word($urandom);
        write_word($urandom);
        pulse_start();
        repeat (5) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_busy got %b want 1", bus.busy); end
        #2 rstn = 1'b0;
        #1;
        n_checks++; if (bus.axiov !== 1'b0)   begin n_fail++; $display("FAIL midrst_axiov got %b want 0", bus.axiov); end
        n_checks++; if (bus.axiod !== 2'b00)  begin n_fail++; $display("FAIL midrst_axiod got %b want 00", bus.axiod); end
        n_checks++; if (bus.busy !== 1'b0)    begin n_fail++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
        n_checks++; if (bus.count !== 3'd0)   begin n_fail++; $display("FAIL midrst_count got %0d want 0", bus.count); end
        n_checks++; if (bus.wr_full !== 1'b0) begin n_fail++; $display("FAIL midrst_wr_full got %b want 0", bus.wr_full); end
        @(negedge clk);
        rstn = 1'b1;
        model_buf.delete();
        @(negedge clk);
        pulse_start();
        exp_q.delete(); add_idle(8);
        capture(exp_q.size(), -1, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL post_rst_start cyc %0d got %b want %b", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_start_with_write();
        clear_buf();
        write_word($urandom);
        write_word($urandom);
        bus.wr_en   = 1'b1;
        bus.wr_data = $urandom;
        pulse_start();
        exp_q.delete(); add_frame(); add_done();
        capture(exp_q.size(), -1, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL start_wr_frame cyc %0d got %b want %b", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (bus.count !== 3'd2) begin n_fail++; $display("FAIL start_wr_count got %0d want 2", bus.count); end
    endtask

    initial begin
        rstn            = 1'b0;
        bus.wr_en       = 1'b0;
        bus.wr_data     = '0;
        bus.clear       = 1'b0;
        bus.start       = 1'b0;
        bus.repeat_mode = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_word();
        test_full();
        test_repeat();
        test_ignored();
        test_reset_mid();
        test_start_with_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dibit_frame_source.md
# dibit_frame_source

Parametrised frame payload source for the RMII transmit path. It buffers up to DEPTH words written by the user and, on a start pulse, serialises them MSB-first as 2-bit dibits on an axiov/axiod stream. The stream feeds the header/bit-order/tether chain. The block pads short frames to a minimum length and enforces an inter-frame gap. In repeat mode it retransmits the same buffer back to back.

## Interface
- WORD_W, 32: buffered word width in bits; must be even and ≥2.
- DEPTH, 16: buffer capacity in words; ≥1.
- MIN_DIBITS, 184: minimum dibits per frame (46 bytes); shorter payloads are zero-padded up to this length.
- IFG_CYCLES, 48: idle cycles (axiov=0) after every frame; ≥1.
- clk  in  1  RMII reference clock (50 MHz); all logic on its rising edge.
- rstn  in  1  asynchronous, active-low reset.
- wr_en  in  1  write wr_data into the buffer.
- wr_data  in  WORD_W  word to buffer.
- clear  in  1  empty the buffer (count := 0).
- start  in  1  single-cycle request to transmit the buffered frame.
- repeat_mode  in  1  retransmit continuously while high.
- wr_full  out  1  count == DEPTH.
- count  out  $clog2(DEPTH+1)  words currently buffered.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse when returning to IDLE.
- axiov  out  1  dibit valid.
- axiod  out  2  dibit; 2'b00 whenever axiov=0.

## Operation
- States: IDLE, SEND, PAD, GAP.
- Buffer is written only in IDLE when wr_full=0. Word goes to index count; count increments. Writes in any other state, or when full, are dropped.
- clear is honoured only in IDLE.
- IDLE→SEND: start=1 and count>0. Latches frame length L = count·WORD_W/2 dibits and resets the word pointer and dibit index. start with count=0, or start while busy, is ignored.
- SEND: per cycle emit the next dibit of the current word, from bits [WORD_W-1:WORD_W-2] downward. Then advance to the next word, word 0 to count-1.
  - After the last dibit: if L < MIN_DIBITS go to PAD, else go to GAP.
- PAD: emit axiov=1, axiod=2'b00 until total emitted dibits = MIN_DIBITS, then go to GAP.
- GAP: axiov=0 for exactly IFG_CYCLES cycles. On the last gap cycle, repeat_mode is sampled:
  - 1 → SEND, restarting at word 0 with the same L.
  - 0 → IDLE, with done=1 for one cycle.
- Buffer contents and count are retained after a frame, so a new start resends them.
- Priority in the same IDLE cycle: clear > start > wr_en. A start cycle drops any write; a clear cycle drops start and write.
- The dibit/total counter is wide enough for max(DEPTH·WORD_W/2, MIN_DIBITS). Neither it nor the word pointer wraps within a frame.
- Reset (rstn=0, any state, any time) immediately forces:
  - state IDLE, count=0;
  - axiov=0, axiod=0, busy=0, done=0, wr_full=0.
  - Buffer RAM contents are don't-care.
  - An aborted frame is truncated without padding or gap.

## Timing
- All outputs are registered.
- The first dibit appears on axiov/axiod in the cycle after start is sampled. busy rises on that same edge.
- Frame lasts max(L, MIN_DIBITS) cycles with axiov=1, contiguously with no bubbles. IFG_CYCLES cycles with axiov=0 follow.
- done asserts in the cycle after the last gap cycle, together with busy=0. A start in that cycle is accepted.
- Repeat mode: the next frame's first dibit immediately follows the last gap cycle, giving a period of max(L,MIN_DIBITS)+IFG_CYCLES.
- count and wr_full update the edge after an accepted wr_en or clear.

## Test plan
Bench parameters: WORD_W=32, DEPTH=4, MIN_DIBITS=24, IFG_CYCLES=6.
- Write 32'hFEED_BEEF, pulse start → 16 valid dibits 3,3,3,2,3,2,3,1,2,3,3,2,3,2,3,3, then 8 dibits of 0 with axiov=1, then 6 cycles axiov=0, then done pulse, busy=0.
- Write 4 words (wr_full=1 after the 4th), then a 5th write → count stays 4. start → 64 contiguous dibits, no PAD, 6 gap cycles, done.
- repeat_mode=1 with 1 word → frames every 30 cycles with identical dibits. Drop repeat_mode mid-frame → the current frame completes, then done.
- start with count=0 → no activity. start while busy → ignored. Write while busy → count unchanged. clear+start same cycle → count=0, no frame.
- Assert rstn=0 mid-SEND → outputs 0 asynchronously, count=0. After release, start → ignored because the buffer is empty.
- start and wr_en in the same IDLE cycle → the write is dropped, L reflects the prior count, and count is unchanged after the frame.
